// File: rtl/axi_line_buffer_pkg.sv
// Shared constants and types for the AXI line buffer: word geometry, line delimiters,
// unpacker state encoding and the kept-byte selection helper.
package axi_line_buffer_pkg;

  localparam int AXI_DATAW = 32;
  localparam int AXI_BYTES = AXI_DATAW / 8;
  localparam int AXI_IDX_W = $clog2(AXI_BYTES);

  localparam logic [7:0] EOL_BYTE = 8'h0A;
  localparam logic [7:0] CR_BYTE  = 8'h0D;

  typedef enum logic [0:0] {
    UNPACK_IDLE = 1'b0,
    UNPACK_BUSY = 1'b1
  } unpack_state_e;

  // Index of the lowest set bit; bytes leave the hold register little-endian.
  function automatic logic [AXI_IDX_W-1:0] lowest_kept(input logic [AXI_BYTES-1:0] mask);
    logic [AXI_IDX_W-1:0] idx;
    idx = {AXI_IDX_W{1'b0}};
    for (int i = AXI_BYTES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = AXI_IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/axi_line_byte_fifo.sv
// DEPTH x 8 byte FIFO with registered pointers and occupancy; the head byte is read
// combinationally from storage. Push while full is dropped, pop while empty is ignored.
module axi_line_byte_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the read side never exposes unwritten entries.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/axi_line_buffer.sv
// Unpacks AXI words into a byte FIFO and releases bytes only once a whole 0x0A-terminated
// line is buffered. Define AXI_LINEBUF_CR_STRIP_EN to drop 0x0D bytes during unpacking.
module axi_line_buffer
  import axi_line_buffer_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [AXI_DATAW-1:0]       s_data,
  input  logic [AXI_BYTES-1:0]       s_keep,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [7:0]                 m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last,
  output logic [$clog2(DEPTH+1)-1:0] lines_pending,
  output logic                       overflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef AXI_LINEBUF_CR_STRIP_EN
  localparam bit CR_STRIP_EN = 1'b1;
`else
  localparam bit CR_STRIP_EN = 1'b0;
`endif

  unpack_state_e        state_q, state_d;
  logic [AXI_DATAW-1:0] hold_data_q, hold_data_d;
  logic [AXI_BYTES-1:0] hold_keep_q, hold_keep_d;
  logic                 ready_en_q;
  logic [CNT_W-1:0]     lines_q, lines_d;
  logic                 flush_q, flush_d;
  logic                 overflow_q, overflow_d;

  logic [AXI_IDX_W-1:0] byte_idx_s;
  logic [7:0]           cur_byte_s;
  logic [AXI_BYTES-1:0] remaining_s;
  logic                 busy_s, have_byte_s, is_cr_s;
  logic                 advance_s, push_s, done_s, accept_s;
  logic                 pop_s, inc_s, dec_s, flush_enter_s;
  logic [7:0]           fifo_head_s;
  logic                 fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0]     fifo_count_s;

  axi_line_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_s),
    .push_data (cur_byte_s),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign byte_idx_s  = lowest_kept(hold_keep_q);
  assign cur_byte_s  = hold_data_q[{byte_idx_s, 3'b000} +: 8];
  assign remaining_s = hold_keep_q & ~(AXI_BYTES'(1) << byte_idx_s);
  assign busy_s      = (state_q == UNPACK_BUSY);
  assign have_byte_s = |hold_keep_q;
  assign is_cr_s     = CR_STRIP_EN && (cur_byte_s == CR_BYTE);

  // A stripped CR still takes its slot in the byte cycle but never waits on FIFO space.
  assign advance_s = busy_s && have_byte_s && (is_cr_s || !fifo_full_s);
  assign push_s    = advance_s && !is_cr_s;
  assign done_s    = busy_s && (!have_byte_s || (advance_s && (remaining_s == {AXI_BYTES{1'b0}})));
  assign s_ready   = ready_en_q && (!busy_s || done_s);
  assign accept_s  = s_valid && s_ready;

  assign m_last  = !fifo_empty_s && (fifo_head_s == EOL_BYTE);
  assign m_data  = fifo_empty_s ? 8'h00 : fifo_head_s;
  assign m_valid = !fifo_empty_s && ((lines_q != {CNT_W{1'b0}}) || flush_q);
  assign pop_s   = m_valid && m_ready;
  assign inc_s   = push_s && (cur_byte_s == EOL_BYTE);
  assign dec_s   = pop_s && m_last;

  assign lines_pending = lines_q;
  assign overflow      = overflow_q;

  // A full FIFO with no complete line can never drain on its own, so flush it.
  assign flush_enter_s = (fifo_count_s == CNT_W'(DEPTH)) && (lines_q == {CNT_W{1'b0}});

  // Unpacker next state: a new word may load in the same cycle the last byte leaves.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_keep_d = hold_keep_q;
    if (accept_s) begin
      state_d     = UNPACK_BUSY;
      hold_data_d = s_data;
      hold_keep_d = s_keep;
    end else if (done_s) begin
      state_d     = UNPACK_IDLE;
      hold_keep_d = {AXI_BYTES{1'b0}};
    end else if (advance_s) begin
      hold_keep_d = remaining_s;
    end else begin
      hold_keep_d = hold_keep_q;
    end
  end

  always_comb begin
    lines_d    = lines_q;
    flush_d    = flush_q;
    overflow_d = overflow_q;
    case ({inc_s, dec_s})
      2'b10:   lines_d = lines_q + CNT_W'(1);
      2'b01:   lines_d = lines_q - CNT_W'(1);
      default: lines_d = lines_q;
    endcase
    if (flush_q) begin
      flush_d = !(fifo_empty_s || (lines_q != {CNT_W{1'b0}}));
    end else begin
      flush_d = flush_enter_s;
    end
    if (!flush_q && flush_enter_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= UNPACK_IDLE;
      hold_data_q <= {AXI_DATAW{1'b0}};
      hold_keep_q <= {AXI_BYTES{1'b0}};
      ready_en_q  <= 1'b0;
      lines_q     <= {CNT_W{1'b0}};
      flush_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_keep_q <= hold_keep_d;
      ready_en_q  <= 1'b1;
      lines_q     <= lines_d;
      flush_q     <= flush_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_axi_line_buffer.sv
// Directed self-checking bench for axi_line_buffer with hand-computed expected bytes,
// line flags, counters and accept/valid timing.
module tb_axi_line_buffer;
  import axi_line_buffer_pkg::*;

  localparam int DEPTH = 64;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                 clk;
  logic                 rstn;
  logic [AXI_DATAW-1:0] s_data;
  logic [AXI_BYTES-1:0] s_keep;
  logic                 s_valid;
  logic                 s_ready;
  logic [7:0]           m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;
  logic [CNT_W-1:0]     lines_pending;
  logic                 overflow;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  logic [7:0]       out_data  [$];
  logic             out_last  [$];
  logic [CNT_W-1:0] out_lines [$];
  int               valid_cyc [$];

  axi_line_buffer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_data        (s_data),
    .s_keep        (s_keep),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .lines_pending (lines_pending),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record each byte transfer (it completes on the next rising edge) and the first valid cycle.
  always @(negedge clk) begin
    if (rstn && m_valid) begin
      valid_cyc.push_back(cyc);
      if (m_ready) begin
        out_data.push_back(m_data);
        out_last.push_back(m_last);
        out_lines.push_back(lines_pending);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    out_data.delete();
    out_last.delete();
    out_lines.delete();
    valid_cyc.delete();
  endtask

  task automatic send_word(input logic [31:0] data, input logic [3:0] keep, output int acc);
    logic ok;
    ok      = 1'b0;
    s_data  = data;
    s_keep  = keep;
    s_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    acc = cyc;
    if (!ok) check_eq("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_data  = 32'h0;
    s_keep  = 4'h0;
  endtask

  task automatic wait_pops(input int n, input int budget);
    for (int t = 0; t < budget && out_data.size() < n; t++) begin
      @(posedge clk);
      #1;
    end
    if (out_data.size() < n) check_eq("pop_timeout", out_data.size(), n);
  endtask

  task automatic expect_out(input string tag, input logic [63:0] bytes, input int n,
                            input logic [7:0] lasts);
    logic [7:0] b;
    check_eq({tag, "_count"}, out_data.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < out_data.size()) begin
        b = bytes[i*8 +: 8];
        check_eq($sformatf("%s_data%0d", tag, i), out_data[i], b);
        check_eq($sformatf("%s_last%0d", tag, i), out_last[i], lasts[i]);
      end
    end
  endtask

  function automatic int first_valid();
    return (valid_cyc.size() > 0) ? valid_cyc[0] : -1000;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_s_ready"}, s_ready, 1'b0);
    check_eq({tag, "_m_valid"}, m_valid, 1'b0);
    check_eq({tag, "_m_last"}, m_last, 1'b0);
    check_eq({tag, "_m_data"}, m_data, 8'h00);
    check_eq({tag, "_lines"}, lines_pending, 7'd0);
    check_eq({tag, "_overflow"}, overflow, 1'b0);
  endtask

  initial begin
    int a1, a2, a3, bad;
    rstn    = 1'b0;
    m_ready = 1'b0;
    idle();

    // Reset state, then s_ready rises one cycle after release
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_ready_after", s_ready, 1'b1);

    // Single full word holding a whole line
    m_ready = 1'b1;
    clear_log();
    send_word(32'h0A434241, 4'hF, a1);
    idle();
    wait_pops(4, 50);
    expect_out("line1", 64'h0A434241, 4, 8'b0000_1000);
    check_eq("line1_valid_latency", first_valid() - a1, 32'd4);
    check_eq("line1_lines_at_pop", (out_lines.size() > 0) ? out_lines[0] : 7'd99, 7'd1);
    check_eq("line1_lines_end", lines_pending, 7'd0);

    // Line spread over two words; second word accepted with no bubble
    clear_log();
    send_word(32'h44434241, 4'hF, a1);
    send_word(32'h00000A45, 4'h3, a2);
    idle();
    wait_pops(6, 50);
    expect_out("line2", 64'h0A4544434241, 6, 8'b0010_0000);
    check_eq("line2_no_bubble", a2 - a1, 32'd4);
    check_eq("line2_valid_latency", first_valid() - a1, 32'd6);

    // Three buffered lines with back-pressure, then drained
    m_ready = 1'b0;
    clear_log();
    for (int i = 0; i < 3; i++) send_word(32'h00000A41, 4'h3, a1);
    idle();
    repeat (4) @(posedge clk);
    #1;
    check_eq("three_lines", lines_pending, 7'd3);
    check_eq("three_valid", m_valid, 1'b1);
    check_eq("three_head", m_data, 8'h41);
    m_ready = 1'b1;
    wait_pops(6, 50);
    expect_out("three", 64'h0A410A410A41, 6, 8'b0010_1010);
    check_eq("three_lines_pop1", (out_lines.size() > 5) ? out_lines[1] : 7'd99, 7'd3);
    check_eq("three_lines_pop3", (out_lines.size() > 5) ? out_lines[3] : 7'd99, 7'd2);
    check_eq("three_lines_pop5", (out_lines.size() > 5) ? out_lines[5] : 7'd99, 7'd1);
    check_eq("three_lines_end", lines_pending, 7'd0);

    // 70 bytes without a line end: fill, overflow flush, then recovery
    clear_log();
    for (int i = 0; i < 17; i++) send_word(32'h55555555, 4'hF, a1);
    send_word(32'h00005555, 4'h3, a1);
    idle();
    wait_pops(70, 400);
    repeat (2) @(posedge clk);
    #1;
    bad = 0;
    foreach (out_data[i]) if (out_data[i] != 8'h55 || out_last[i]) bad++;
    check_eq("ovf_bytes", out_data.size(), 32'd70);
    check_eq("ovf_bad_bytes", bad, 32'd0);
    check_eq("ovf_flag", overflow, 1'b1);
    check_eq("ovf_s_ready", s_ready, 1'b1);
    check_eq("ovf_drained", m_valid, 1'b0);
    clear_log();
    send_word(32'h00000A42, 4'h3, a1);
    idle();
    wait_pops(2, 50);
    expect_out("ovf_after", 64'h0A42, 2, 8'b0000_0010);
    check_eq("ovf_sticky", overflow, 1'b1);

    // Pop of one 0x0A in the same cycle as a push of another
    clear_log();
    send_word(32'h00000A41, 4'h3, a1);
    send_word(32'h00000A43, 4'h3, a2);
    idle();
    check_eq("coincide_accept_gap", a2 - a1, 32'd2);
    for (int t = 0; t < 20 && cyc < a2 + 2; t++) begin
      @(posedge clk);
      #1;
    end
    check_eq("coincide_pops", out_data.size(), 32'd2);
    check_eq("coincide_lines", lines_pending, 7'd1);
    wait_pops(4, 50);
    expect_out("coincide", 64'h0A430A41, 4, 8'b0000_1010);
    check_eq("coincide_lines_end", lines_pending, 7'd0);

    // Reset pulsed mid-word clears everything at once
    m_ready = 1'b0;
    clear_log();
    send_word(32'h44434241, 4'hF, a1);
    idle();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_ready_after", s_ready, 1'b1);
    m_ready = 1'b1;
    clear_log();
    send_word(32'h0000000A, 4'h1, a1);
    idle();
    wait_pops(1, 50);
    expect_out("lone_eol", 64'h0A, 1, 8'b0000_0001);

    // Empty-keep word is consumed; sparse keep selects bytes 1 and 3
    clear_log();
    send_word(32'h0A0A0A0A, 4'h0, a1);
    send_word(32'h0A994499, 4'hA, a3);
    idle();
    wait_pops(2, 50);
    repeat (4) @(posedge clk);
    #1;
    expect_out("sparse", 64'h0A44, 2, 8'b0000_0010);

    // Carriage return handling
    clear_log();
    send_word(32'h00000A0D, 4'h3, a1);
    idle();
`ifdef AXI_LINEBUF_CR_STRIP_EN
    wait_pops(1, 50);
    repeat (4) @(posedge clk);
    #1;
    expect_out("cr", 64'h0A, 1, 8'b0000_0001);
`else
    wait_pops(2, 50);
    repeat (4) @(posedge clk);
    #1;
    expect_out("cr", 64'h0A0D, 2, 8'b0000_0010);
`endif
    check_eq("cr_lines_end", lines_pending, 7'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/axi_line_buffer.md
Name: axi_line_buffer

Overview:
Consumes AXI_DATAW-wide words from the AXI receive path and unpacks them little-endian (byte 0 = data[7:0] first) into a byte FIFO. It releases bytes downstream only once a complete line, terminated by 0x0A, is buffered. Sits directly downstream of the word-level end-of-line detector and feeds the byte-serial command/program loader. Bytes are counted per line so the consumer never stalls mid-line.

Parameters:
DEPTH, 64, byte FIFO capacity; power of two, >= AXI_DATAW/8.
AXI_DATAW, from shared const package (32), input word width; multiple of 8.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
s_data  in  AXI_DATAW  input word
s_keep  in  AXI_DATAW/8  per-byte valid; bytes with keep=0 skipped (any pattern legal)
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid&s_ready
m_data  out  8  output byte
m_valid  out  1  output byte valid
m_ready  in  1  downstream accepts byte
m_last  out  1  high with m_data==0x0A (end of line)
lines_pending  out  $clog2(DEPTH+1)  complete lines held in FIFO
overflow  out  1  sticky: a line exceeded DEPTH bytes

Behaviour:
- Reset (rstn=0, async): FIFO empty, pointers 0, hold register empty, s_ready=0 during reset then 1 the first cycle after release, m_valid=0, m_last=0, m_data=0, lines_pending=0, overflow=0, state UNPACK_IDLE.
- Hold register + byte index; FSM UNPACK_IDLE -> UNPACK_BUSY on word accept; UNPACK_BUSY writes one kept byte per cycle when FIFO not full (stalls while full); returns to UNPACK_IDLE after the highest kept byte is written; an accept with s_keep=0 is consumed and returns to UNPACK_IDLE the next cycle.
- s_ready = IDLE, or BUSY with the final kept byte being written this cycle (back-to-back words, no bubble).
- Latency: word accepted at edge N -> byte 0 in FIFO at edge N+1, byte k at N+1+k absent full-stalls.
- lines_pending: +1 on FIFO write of 0x0A, -1 on m_valid&m_ready&m_last; both in the same cycle -> unchanged.
- m_valid = FIFO non-empty and (lines_pending>0 or flush). m_data/m_last are FIFO head (combinational from storage, registered pointers).
- Flush: entered when FIFO full and lines_pending==0; sets overflow (sticky to reset); while in flush the head bytes are released with m_last=0 until FIFO empty or lines_pending>0, then flush clears.
- Simultaneous push and pop when full: pop frees slot, push blocked that cycle (full evaluated from registered state).
- Pointers wrap modulo DEPTH; occupancy counter width $clog2(DEPTH+1).
- m_valid once high holds with stable m_data until m_ready.

Optional Feature:
AXI_LINEBUF_CR_STRIP_EN: defined -> bytes equal 0x0D are consumed by the unpacker without FIFO write (costs the same one cycle as a write). Undefined -> 0x0D buffered and delivered like any byte.

Decomposition:
- Shared package: AXI_DATAW, AXI_BYTES=AXI_DATAW/8, EOL_BYTE=8'h0A, CR_BYTE=8'h0D, unpack state enum.
- One sub-module: axi_line_byte_fifo (DEPTH x 8 storage, push/pop, full/empty, count); unpacker, line counter and flush control stay in top.

Test Plan:
- Word 32'h0A434241, keep 4'hF, m_ready=1 -> m_valid first after 0x0A write; bytes 41,42,43,0A out; m_last only on 0A; lines_pending 1->0.
- Words 32'h44434241 then 32'h00000A45 keep 4'h3 -> no m_valid until second word unpacked; output 41..45,0A; second word accepted with no bubble cycle.
- m_ready=0, feed 3 lines "A\n" (keep 4'h3) -> lines_pending=3; then m_ready=1 -> 6 bytes, three m_last pulses, lines_pending 3,2,1,0.
- DEPTH=64, 70 bytes 0x55 without 0x0A -> FIFO fills, overflow=1, 64+ bytes drained with m_last=0, s_ready resumes; subsequent "B\n" delivered normally.
- Pop of 0x0A coinciding with push of another 0x0A -> lines_pending unchanged that cycle.
- rstn pulsed low mid-word -> all outputs at reset values immediately; next word 32'h0000000A keep 4'h1 -> single byte 0A with m_last; with AXI_LINEBUF_CR_STRIP_EN, word 32'h00000A0D keep 4'h3 -> only 0A delivered.
